rom_lookup_arbiter: RTL and testbench

Shares one registered dual-port lookup ROM among NUM_REQ independent requesters, such as the SME hash/rule-table lookup lanes. Each cycle it grants up to two pending lookups round-robin, one to ROM port A and one to port B. It tracks in-flight lookups with an ID/valid tag pipeline and returns each ROM word to the requester that issued it. It sits between the matcher lanes and the ROM instance.

---
 rtl/rom_lookup_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_rom_lookup_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_lookup_arbiter.sv
// rom_lookup_arbiter
//   Shares one registered dual-port lookup ROM among NUM_REQ requesters.
//   Each cycle up to two pending lookups are granted round-robin: the first
//   valid requester at or after rr_ptr gets ROM port A, and the next valid one
//   in the same scan gets port B. A valid/ID tag pipeline follows every lookup
//   through the ROM so that each returned word is steered back to its issuer.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   hold            suppresses new grants; lookups already in flight complete
//   req_valid       per-requester lookup request            [NUM_REQ]
//   req_addr        per-requester address, slice i at [i*AWIDTH +: AWIDTH]
//   req_ready       combinational grant                     [NUM_REQ]
//   rom_address_a/b registered ROM addresses
//   rom_qa/qb       ROM read data, valid ROM_LATENCY cycles after the address
//   resp_valid      one-cycle response pulse per requester  [NUM_REQ]
//   resp_data       response word, slice i at [i*DWIDTH +: DWIDTH]
//
// Optional build macro ROM_ARB_STATS_EN adds:
//   stat_lookups    32-bit count of granted lookups
//   stat_stall      32-bit count of cycles in which a valid request went ungranted

module rom_lookup_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*AWIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [AWIDTH-1:0]           rom_address_a,
  output logic [AWIDTH-1:0]           rom_address_b,
  input  logic [DWIDTH-1:0]           rom_qa,
  input  logic [DWIDTH-1:0]           rom_qb,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [NUM_REQ*DWIDTH-1:0]   resp_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_lookups,
  output logic [31:0]                 stat_stall
`endif
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Tag stage whose contents line up with valid rom_qa/rom_qb.
  localparam int EXIT = ROM_LATENCY;

  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] rr_ptr_next;
  logic           grant_a;
  logic           grant_b;
  logic [IDW-1:0] idx_a;
  logic [IDW-1:0] idx_b;
  logic [IDW-1:0] scan_idx;

  // Round-robin scan: walk NUM_REQ positions starting at rr_ptr; the first
  // valid requester takes port A, the second takes port B.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    idx_a     = '0;
    idx_b     = '0;
    scan_idx  = '0;
    req_ready = '0;
    if (!hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = IDW'((int'(rr_ptr_reg) + k) % NUM_REQ);
        if (req_valid[scan_idx]) begin
          if (!grant_a) begin
            grant_a             = 1'b1;
            idx_a               = scan_idx;
            req_ready[scan_idx] = 1'b1;
          end else if (!grant_b) begin
            grant_b             = 1'b1;
            idx_b               = scan_idx;
            req_ready[scan_idx] = 1'b1;
          end
        end
      end
    end
  end

  // Pointer moves just past the last requester served this cycle.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_b) begin
      rr_ptr_next = IDW'((int'(idx_b) + 1) % NUM_REQ);
    end else if (grant_a) begin
      rr_ptr_next = IDW'((int'(idx_a) + 1) % NUM_REQ);
    end
  end

  // Ungranted ports keep their old address; the matching tag is invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      rom_address_a <= '0;
      rom_address_b <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (grant_a) rom_address_a <= req_addr[idx_a*AWIDTH +: AWIDTH];
      if (grant_b) rom_address_b <= req_addr[idx_b*AWIDTH +: AWIDTH];
    end
  end

  // Tag pipeline: stage 0 is loaded with the grant, in step with the address
  // register; stage EXIT is presented alongside valid ROM data.
  logic [ROM_LATENCY:0] tag_a_valid_reg;
  logic [ROM_LATENCY:0] tag_b_valid_reg;
  logic [IDW-1:0]       tag_a_id_reg [ROM_LATENCY+1];
  logic [IDW-1:0]       tag_b_id_reg [ROM_LATENCY+1];

  generate
    for (genvar gi = 0; gi <= ROM_LATENCY; gi++) begin : g_tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_a_valid_reg[gi] <= 1'b0;
          tag_b_valid_reg[gi] <= 1'b0;
          tag_a_id_reg[gi]    <= '0;
          tag_b_id_reg[gi]    <= '0;
        end else if (gi == 0) begin
          tag_a_valid_reg[gi] <= grant_a;
          tag_b_valid_reg[gi] <= grant_b;
          tag_a_id_reg[gi]    <= idx_a;
          tag_b_id_reg[gi]    <= idx_b;
        end else begin
          tag_a_valid_reg[gi] <= tag_a_valid_reg[(gi > 0) ? gi - 1 : 0];
          tag_b_valid_reg[gi] <= tag_b_valid_reg[(gi > 0) ? gi - 1 : 0];
          tag_a_id_reg[gi]    <= tag_a_id_reg[(gi > 0) ? gi - 1 : 0];
          tag_b_id_reg[gi]    <= tag_b_id_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  // Per-requester hit decode at the exit stage. A and B can never hit the
  // same requester in one cycle, since a requester gets one grant per cycle.
  logic [NUM_REQ-1:0] hit_a;
  logic [NUM_REQ-1:0] hit_b;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit
      assign hit_a[gi] = tag_a_valid_reg[EXIT] && (tag_a_id_reg[EXIT] == IDW'(gi));
      assign hit_b[gi] = tag_b_valid_reg[EXIT] && (tag_b_id_reg[EXIT] == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= hit_a | hit_b;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hit_a[i]) begin
          resp_data[i*DWIDTH +: DWIDTH] <= rom_qa;
        end else if (hit_b[i]) begin
          resp_data[i*DWIDTH +: DWIDTH] <= rom_qb;
        end
      end
    end
  end

`ifdef ROM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_stall   <= '0;
    end else begin
      stat_lookups <= stat_lookups + 32'(grant_a) + 32'(grant_b);
      if (|(req_valid & ~req_ready)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Testbench for rom_lookup_arbiter (default parameters). Stimulus pushes the
// expected response of every accepted lookup into a scoreboard queue; an
// independent monitor pops and compares on every cycle a response is due or
// presented. Exercises the ROM_ARB_STATS_EN counters when built with it.

module tb_rom_lookup_arbiter;

  localparam int N        = 4;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int LAT      = 1;
  localparam int RESP_LAT = 2 + LAT;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_address_a;
  logic [AW-1:0]   rom_address_b;
  logic [DW-1:0]   rom_qa = '0;
  logic [DW-1:0]   rom_qb = '0;
  logic [N-1:0]    resp_valid;
  logic [N*DW-1:0] resp_data;
`ifdef ROM_ARB_STATS_EN
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_stall;
`endif

  rom_lookup_arbiter #(
    .NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .ROM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_address_a(rom_address_a), .rom_address_b(rom_address_b),
    .rom_qa(rom_qa), .rom_qb(rom_qb),
    .resp_valid(resp_valid), .resp_data(resp_data)
`ifdef ROM_ARB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: mem[a] = a ^ 0xA0, so mem[0x05] = 0xA5.
  function automatic logic [7:0] rom_word(input logic [7:0] a);
    return a ^ 8'hA0;
  endfunction

  // Registered dual-port ROM, one cycle from address edge to data.
  always @(posedge clk) begin
    rom_qa <= rom_word(rom_address_a);
    rom_qb <= rom_word(rom_address_b);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         req;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_data [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: collect everything due this cycle and compare with the outputs.
  always @(negedge clk) begin
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    exp_t            e;
    ev = '0;
    ed = '0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      ev[e.req] = 1'b1;
      ed[e.req*DW +: DW] = e.data;
    end
    if (resp_valid != '0 || ev != '0) begin
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      for (int i = 0; i < N; i++) begin
        if (ev[i]) begin
          last_data[i] = ed[i*DW +: DW];
          if (resp_valid[i]) chk($sformatf("resp_data[%0d]", i), 64'(resp_data[i*DW +: DW]), 64'(ed[i*DW +: DW]));
        end
      end
      $display("cyc=%0d resp_valid=%b resp_data=%h expected_valid=%b", cyc, resp_valid, resp_data, ev);
    end
  end

  // One clock of stimulus; checks req_ready and queues expected responses.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic h, input logic [N-1:0] exp_rdy, input bit track);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    hold      = h;
    @(negedge clk);
    $display("cyc=%0d req_valid=%b hold=%b req_addr=%h req_ready=%b", cyc, v, h, a, req_ready);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (track) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && exp_rdy[i]) begin
          e.req  = i;
          e.data = rom_word(a[i*AW +: AW]);
          e.due  = cyc + RESP_LAT;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0, 1'b1);
  endtask

`ifdef ROM_ARB_STATS_EN
  logic [31:0] lk0;
  logic [31:0] st0;
`endif

  initial begin
    for (int i = 0; i < N; i++) last_data[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({resp_valid, resp_data, rom_address_a, rom_address_b, req_ready}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single lookup: req0 @0x05 -> port A only, 0xA5 three cycles later
    step(4'b0001, 32'h0000_0005, 1'b0, 4'b0001, 1'b1);        // rr -> 1
    step(4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1);
    chk("rom_address_a_single", 64'(rom_address_a), 64'h05);
    chk("rom_address_b_unused", 64'(rom_address_b), 64'h00);
    idle(3);

    // Bring rr_ptr back to 0 with a lone grant to req3
    step(4'b1000, 32'h4c00_0000, 1'b0, 4'b1000, 1'b1);        // rr -> 0

    // All four valid: {0,1}, {2,3}, {0,1}, {2,3}
    step(4'b1111, 32'h1312_1110, 1'b0, 4'b0011, 1'b1);
    step(4'b1111, 32'h1716_1514, 1'b0, 4'b1100, 1'b1);
    step(4'b1111, 32'h1b1a_1918, 1'b0, 4'b0011, 1'b1);
    step(4'b1111, 32'h1f1e_1d1c, 1'b0, 4'b1100, 1'b1);        // rr -> 0
    idle(4);

    // Wrap-around: set rr_ptr=3, then req3 on A and req0 on B
    step(4'b0100, 32'h0022_0000, 1'b0, 4'b0100, 1'b1);        // rr -> 3
    step(4'b1001, 32'h3300_0030, 1'b0, 4'b1001, 1'b1);        // rr -> 1
    step(4'b1111, 32'h4342_4140, 1'b0, 4'b0110, 1'b1);        // rr -> 3
    chk("rom_address_a_wrap", 64'(rom_address_a), 64'h33);
    chk("rom_address_b_wrap", 64'(rom_address_b), 64'h30);
    step(4'b1111, 32'h4746_4544, 1'b0, 4'b1001, 1'b1);        // rr -> 1
    chk("rom_address_a_pair", 64'(rom_address_a), 64'h41);
    chk("rom_address_b_pair", 64'(rom_address_b), 64'h42);
    idle(4);

    // Hold with two lookups in flight
    step(4'b0011, 32'h0000_5150, 1'b0, 4'b0011, 1'b1);        // A=1, B=0, rr -> 1
    step(4'b1111, 32'h5756_5554, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 32'h5756_5554, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 32'h5756_5554, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 32'h6362_6160, 1'b0, 4'b0110, 1'b1);        // rr was frozen at 1; -> 3
    idle(4);

    // Reset one cycle after two grants: both lookups are dropped
    step(4'b1111, 32'h7372_7170, 1'b0, 4'b1001, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) last_data[i] = '0;
    @(negedge clk);
    chk("midrun_reset_outputs", 64'({resp_valid, resp_data, rom_address_a, rom_address_b, req_ready}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    step(4'b1111, 32'h8382_8180, 1'b0, 4'b0011, 1'b1);        // rr restarted at 0; -> 2
    idle(4);

`ifdef ROM_ARB_STATS_EN
    lk0 = stat_lookups;
    st0 = stat_stall;
    for (int k = 0; k < 10; k++) begin
      step(4'b1111, 32'h9392_9190 + 32'(k) * 32'h0404_0404, 1'b0,
           (k % 2 == 0) ? 4'b1100 : 4'b0011, 1'b1);
    end
    idle(1);
    chk("stat_lookups_delta", 64'(stat_lookups - lk0), 64'd20);
    chk("stat_stall_delta", 64'(stat_stall - st0), 64'd10);
    idle(4);
`endif

    // Drain, then confirm resp_data holds the last word of each requester
    idle(5);
    chk("resp_data_hold", 64'(resp_data), 64'({last_data[3], last_data[2], last_data[1], last_data[0]}));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
